// File: rtl/int_pkg.sv
// Shared types and address constants for the external interrupt responder
// and its window decoder.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACKED   = 2'd2
  } state_t;

  localparam logic [31:0] ACK_ADDR_DEF = 32'h0000_7f20;
  localparam logic [31:0] OFF_ACK      = 32'd0;
  localparam logic [31:0] OFF_STAT     = 32'd4;
  localparam logic [31:0] OFF_SPUR     = 32'd8;

endpackage

// File: rtl/int_win_decode.sv
// Combinational decode of the 3-word acknowledge/status window: word selects,
// ack/clear strobes and the gated acknowledge outputs toward the interrupt source.
module int_win_decode
  import int_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEF
) (
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byteen,
  output logic        o_win,
  output logic        o_sel_ack,
  output logic        o_sel_stat,
  output logic        o_sel_spur,
  output logic        o_ack,
  output logic        o_clr,
  output logic [31:0] o_int_addr,
  output logic [3:0]  o_int_byteen
);

  logic [31:0] w_word;
  logic        w_store;
  logic        w_unused_wdata;

  assign w_word     = i_addr & ~32'h3;
  assign w_store    = |i_byteen;
  assign o_sel_ack  = (w_word == ACK_ADDR + OFF_ACK);
  assign o_sel_stat = (w_word == ACK_ADDR + OFF_STAT);
  assign o_sel_spur = (w_word == ACK_ADDR + OFF_SPUR);
  assign o_win      = o_sel_ack | o_sel_stat | o_sel_spur;

  assign o_ack = w_store & o_sel_ack;
  // Only bit 0 of the store data carries meaning (the clear command).
  assign o_clr = w_store & o_sel_stat & i_wdata[0];
  assign w_unused_wdata = ^i_wdata[31:1];

  assign o_int_addr   = (w_store && o_win) ? i_addr   : 32'h0;
  assign o_int_byteen = (w_store && o_win) ? i_byteen : 4'h0;

endmodule

// File: rtl/int_responder.sv
// CPU-side end of the external interrupt handshake with service statistics.
// Define INT_SPURIOUS_CNT_EN to add the saturating spurious-ack counter at +8.
module int_responder
  import int_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEF,
  parameter int          LAT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             interrupt,
  input  logic [31:0]      m_addr,
  input  logic [31:0]      m_wdata,
  input  logic [3:0]       m_byteen,
  output logic [31:0]      m_int_addr,
  output logic [3:0]       m_int_byteen,
  output logic             hwint,
  output logic             rd_hit,
  output logic [31:0]      rd_data,
  output logic [LAT_W-1:0] svc_count
);

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  state_t           r_state;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] r_last_lat;
  logic [LAT_W-1:0] r_svc;
  logic             w_win, w_sel_ack, w_sel_stat, w_sel_spur;
  logic             w_ack, w_clr;
  logic [31:0]      w_spur_rd;

  int_win_decode #(.ACK_ADDR(ACK_ADDR)) u_dec (
    .i_addr      (m_addr),
    .i_wdata     (m_wdata),
    .i_byteen    (m_byteen),
    .o_win       (w_win),
    .o_sel_ack   (w_sel_ack),
    .o_sel_stat  (w_sel_stat),
    .o_sel_spur  (w_sel_spur),
    .o_ack       (w_ack),
    .o_clr       (w_clr),
    .o_int_addr  (m_int_addr),
    .o_int_byteen(m_int_byteen)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lat      <= '0;
      r_last_lat <= '0;
      r_svc      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (interrupt) begin
            r_state <= PENDING;
            r_lat   <= '0;
          end
        end
        PENDING: begin
          // The ack cycle itself is not counted toward latency.
          if (w_ack) begin
            r_state    <= ACKED;
            r_last_lat <= r_lat;
            r_svc      <= r_svc + LAT_ONE;
          end else if (r_lat != LAT_MAX) begin
            r_lat <= r_lat + LAT_ONE;
          end
        end
        ACKED: begin
          if (!interrupt) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_clr) begin
        r_svc      <= '0;
        r_last_lat <= '0;
      end
    end
  end

`ifdef INT_SPURIOUS_CNT_EN
  logic [LAT_W-1:0] r_spur;
  logic             w_spur_ack;

  assign w_spur_ack = w_ack && (r_state != PENDING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spur <= '0;
    end else if (w_clr) begin
      r_spur <= '0;
    end else if (w_spur_ack && (r_spur != LAT_MAX)) begin
      r_spur <= r_spur + LAT_ONE;
    end
  end

  assign w_spur_rd = 32'(r_spur);
`else
  assign w_spur_rd = 32'h0;
`endif

  assign hwint     = (r_state == PENDING);
  assign svc_count = r_svc;
  assign rd_hit    = w_win;

  always_comb begin
    rd_data = 32'h0;
    if (w_sel_ack)       rd_data = {30'b0, (r_state == ACKED), hwint};
    else if (w_sel_stat) rd_data = {16'(r_svc), 16'(r_last_lat)};
    else if (w_sel_spur) rd_data = w_spur_rd;
  end

endmodule

// File: tb/tb_int_responder.sv
// Self-checking bench for int_responder: read results go through an expected
// queue, other outputs are compared inline in each scenario task.
module tb_int_responder;

  localparam logic [31:0] A = 32'h0000_7f20;
`ifdef INT_SPURIOUS_CNT_EN
  localparam bit SPUR_EN = 1'b1;
`else
  localparam bit SPUR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_byteen;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        hwint, rd_hit;
  logic [31:0] rd_data;
  logic [15:0] svc_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, e;
  int m_svc  = 0;
  int m_spur = 0;

  int_responder dut (
    .clk         (clk),
    .reset       (reset),
    .interrupt   (interrupt),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_byteen    (m_byteen),
    .m_int_addr  (m_int_addr),
    .m_int_byteen(m_int_byteen),
    .hwint       (hwint),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
    .svc_count   (svc_count)
  );

  always #5 clk = ~clk;

  // Move to the next cycle; inputs are driven 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    cyc();
    m_addr = a; m_wdata = '0; m_byteen = 4'h0;
    #2;
    v = rd_data;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc();
    m_addr = a; m_wdata = d; m_byteen = be;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; interrupt = 1'b0;
    m_addr = '0; m_wdata = '0; m_byteen = '0;
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (hwint !== 1'b0) begin n_fail++; $display("FAIL reset_hwint: got %b want 0", hwint); end
    n_checks++;
    if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: got hit=%b data=%h want 0/0", rd_hit, rd_data);
    end
    n_checks++;
    if (svc_count !== 16'h0) begin n_fail++; $display("FAIL reset_svc: got %h want 0", svc_count); end
    n_checks++;
    if (m_int_addr !== 32'h0 || m_int_byteen !== 4'h0) begin
      n_fail++; $display("FAIL reset_mint: got %h/%h want 0/0", m_int_addr, m_int_byteen);
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    cyc();
    interrupt = 1'b1;
    #2;
    n_checks++;
    if (hwint !== 1'b0) begin n_fail++; $display("FAIL basic_pre: got %b want 0", hwint); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 4) begin m_addr = A; m_wdata = $urandom; m_byteen = 4'hf; end
      #2;
      n_checks++;
      if (hwint !== 1'b1) begin n_fail++; $display("FAIL basic_hwint_%0d: got %b want 1", i, hwint); end
      if (i == 4) begin
        n_checks++;
        if (m_int_addr !== A || m_int_byteen !== 4'hf) begin
          n_fail++; $display("FAIL basic_mint: got %h/%h want %h/f", m_int_addr, m_int_byteen, A);
        end
      end
    end
    m_svc = 1;
    exp_q.push_back({16'(m_svc), 16'd4});
    rd(A + 32'd4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL basic_stat: got %h want %h", got, e); end
    n_checks++;
    if (hwint !== 1'b0) begin n_fail++; $display("FAIL basic_hwint_lo: got %b want 0", hwint); end
  endtask

  task automatic test_hold_acked();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(32'h2);
      rd(A, got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL hold_%0d: got %h want %h", i, got, e); end
    end
    cyc();
    interrupt = 1'b0;
    exp_q.push_back(32'h0);
    rd(A, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL hold_idle: got %h want %h", got, e); end
    cyc();
    interrupt = 1'b1;
    exp_q.push_back(32'h1);
    rd(A, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL hold_retrig: got %h want %h", got, e); end
    // One non-ack PENDING cycle (the read above) precedes this ack.
    st(A, 32'h0, 4'hf);
    interrupt = 1'b0;
    m_svc = 2;
    exp_q.push_back(32'h2);
    exp_q.push_back({16'(m_svc), 16'd1});
    rd(A, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL hold_acked2: got %h want %h", got, e); end
    rd(A + 32'd4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL hold_stat: got %h want %h", got, e); end
  endtask

  task automatic test_spurious();
    st(A + 32'd1, 32'h0, 4'b0010);
    n_checks++;
    if (m_int_byteen !== 4'b0010 || m_int_addr !== A + 32'd1) begin
      n_fail++; $display("FAIL spur_mint: got %h/%h want %h/2", m_int_addr, m_int_byteen, A + 32'd1);
    end
    m_spur = 1;
    exp_q.push_back(32'h0);
    exp_q.push_back(SPUR_EN ? 32'(m_spur) : 32'h0);
    rd(A, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL spur_state: got %h want %h", got, e); end
    rd(A + 32'd8, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL spur_cnt1: got %h want %h", got, e); end
    // Ack on the same edge the interrupt rises: spurious, yet still enters PENDING.
    st(A, 32'h0, 4'hf);
    interrupt = 1'b1;
    m_spur = 2;
    exp_q.push_back(32'h1);
    exp_q.push_back(SPUR_EN ? 32'(m_spur) : 32'h0);
    rd(A, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL spur_rise_state: got %h want %h", got, e); end
    rd(A + 32'd8, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL spur_cnt2: got %h want %h", got, e); end
    st(A + 32'd4, 32'h1, 4'hf);
    m_svc = 0; m_spur = 0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    rd(A + 32'd4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL clr_stat: got %h want %h", got, e); end
    rd(A + 32'd8, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL clr_spur: got %h want %h", got, e); end
    rd(A, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL clr_state: got %h want %h", got, e); end
  endtask

  task automatic test_saturate();
    repeat (70000) cyc();
    st(A, 32'h0, 4'hf);
    interrupt = 1'b0;
    m_svc = 1;
    exp_q.push_back({16'(m_svc), 16'hffff});
    rd(A + 32'd4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sat_stat: got %h want %h", got, e); end
    n_checks++;
    if (svc_count !== 16'(m_svc)) begin n_fail++; $display("FAIL sat_svc: got %h want %h", svc_count, 16'(m_svc)); end
  endtask

  task automatic test_reset_mid();
    cyc();
    interrupt = 1'b1;
    cyc();
    #2;
    n_checks++;
    if (hwint !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b want 1", hwint); end
    #1;
    reset = 1'b1;
    interrupt = 1'b0;
    #1;
    n_checks++;
    if (hwint !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got %b want 0", hwint); end
    cyc();
    cyc();
    reset = 1'b0;
    m_svc = 0; m_spur = 0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      rd(A + 32'(4 * i), got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL rstmid_rd%0d: got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      cyc();
      interrupt = 1'b1; m_byteen = 4'h0;
      st(A, 32'h0, 4'hf);
      interrupt = 1'b0;
      cyc();
      m_byteen = 4'h0;
      m_svc++;
    end
    n_checks++;
    if (svc_count !== 16'(m_svc)) begin n_fail++; $display("FAIL b2b_svc: got %h want %h", svc_count, 16'(m_svc)); end
    exp_q.push_back({16'(m_svc), 16'd0});
    rd(A + 32'd4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_stat: got %h want %h", got, e); end
    st(A + 32'd4, 32'h1, 4'hf);
    m_svc = 0;
    exp_q.push_back(32'h0);
    rd(A + 32'd4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_clr: got %h want %h", got, e); end
    n_checks++;
    if (svc_count !== 16'(m_svc)) begin n_fail++; $display("FAIL b2b_clr_svc: got %h want 0", svc_count); end
    st(32'h0000_7f30, $urandom, 4'hf);
    n_checks++;
    if (rd_hit !== 1'b0 || m_int_byteen !== 4'h0 || m_int_addr !== 32'h0) begin
      n_fail++; $display("FAIL outside: got hit=%b be=%h addr=%h want 0/0/0", rd_hit, m_int_byteen, m_int_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_acked();
    test_spurious();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_responder.md
Name: int_responder

Overview:
- CPU-side end of the external interrupt handshake.
- Latches the external `interrupt` level and raises a hardware-interrupt request to CP0.
- Decodes the handler's acknowledge store to 0x7f20 and drives the `m_int_addr`/`m_int_byteen` acknowledge outputs.
- Keeps service statistics readable over the bridge; sits in the bridge next to the timers.

Parameters:
- ACK_ADDR, 32'h00007f20, word address of the acknowledge/status window (3 words: +0 ack, +4 stats, +8 spurious).
- LAT_W, 16, width of the latency and service counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- interrupt  in  1  external interrupt level, sampled on posedge clk
- m_addr  in  32  M-stage data address
- m_wdata  in  32  M-stage store data (ignored except for the clear command)
- m_byteen  in  4  M-stage store byte enables; 0 means no store
- m_int_addr  out  32  acknowledge address toward the interrupt source
- m_int_byteen  out  4  acknowledge byte enables toward the interrupt source
- hwint  out  1  interrupt request to CP0 (IP[2])
- rd_hit  out  1  m_addr falls in the 3-word window
- rd_data  out  32  load data for the window
- svc_count  out  LAT_W  number of serviced interrupts

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; hwint=0; counters=0; int_q=0.
  - m_int_addr=0; m_int_byteen=0; rd_hit=0; rd_data=0.
- Decode (combinational):
  - win = (m_addr & ~32'h3) within ACK_ADDR..ACK_ADDR+8.
  - ack = |m_byteen && word==ACK_ADDR.
  - clr = |m_byteen && word==ACK_ADDR+4 && m_wdata[0].
  - m_int_addr = m_addr and m_int_byteen = m_byteen whenever |m_byteen && win; both 0 otherwise.
  - The source samples these at negedge of the same cycle.
- FSM:
  - IDLE: interrupt=1 at posedge → PENDING; hwint=1 from that edge. Latency counter cleared to 0.
  - PENDING: hwint=1; latency counter +1 per cycle, saturating at 2^LAT_W-1.
    - ack at posedge → ACKED; hwint=0 from that edge.
    - last_lat captures the counter value, not counting the ack cycle.
    - svc_count +1 (wraps modulo 2^LAT_W).
  - ACKED: hwint=0; any level still high is ignored (no re-trigger). interrupt=0 at posedge → IDLE.
- Simultaneous events:
  - ack in IDLE or ACKED: forwarded on the m_int outputs, no state change, counted as spurious.
  - ack in IDLE on the same edge interrupt rises: spurious ack counted, state → PENDING.
  - clr and ack on the same edge are impossible (different addresses).
  - clr: svc_count, last_lat and spurious counter → 0; FSM state unaffected.
  - clr while PENDING and an ack later: svc_count ends at 1.
- Reads (combinational; rd_hit=1 when win):
  - +0 returns {30'b0, state==ACKED, hwint}.
  - +4 returns {svc_count, last_lat}, each zero-extended to 16 bits.
  - +8 returns the spurious counter or 0 (see Optional Feature).
- Reset mid-PENDING: hwint drops immediately (async); the in-progress count is lost.

Optional Feature:
- Macro: INT_SPURIOUS_CNT_EN.
- Defined: LAT_W-bit spurious-ack counter, +1 per spurious ack, saturating; readable at +8; cleared by clr or reset.
- Undefined: no counter flops; +8 reads 32'h0; spurious acks are still forwarded on m_int_*.

Decomposition:
- Shared package `int_pkg`:
  - state enum: IDLE=2'd0, PENDING=2'd1, ACKED=2'd2.
  - ACK_ADDR default and the offsets OFF_ACK=0, OFF_STAT=4, OFF_SPUR=8.
- One sub-module, `int_win_decode`: combinational window/ack/clr decode, reused by the bridge.
- FSM and counters stay in `int_responder`.

Test Plan:
- Raise interrupt at cycle 10, store sw to 0x7f20 at cycle 15 → hwint=1 cycles 11..15, 0 after the cycle-15 edge; m_int_addr=0x7f20 and m_int_byteen=4'hf during cycle 15; read +4 → 0x00010004.
- Hold interrupt=1 for 20 cycles after ack → hwint stays 0 and state==ACKED; drop interrupt → IDLE next edge; re-raise → hwint=1 again.
- sb to 0x7f21 (byteen=4'b0010) while IDLE → m_int_byteen=4'b0010; state unchanged; +8 reads 1 with INT_SPURIOUS_CNT_EN, 0 without.
- Keep PENDING for 70000 cycles (LAT_W=16), then ack → last_lat=16'hFFFF; svc_count=1.
- Assert reset mid-PENDING (async, between edges) → hwint=0 immediately; all reads return 0 after release.
- Three ack cycles, then sw 0x1 to 0x7f24 → svc_count=0 and +4 reads 0; a store to 0x7f30 → rd_hit=0 and m_int_byteen=0.
